// File: rtl/tmp101_pkg.sv
// Shared types and widths for the TMP101 reading assembler.
// Consumed by the top and the optional alert comparator.
package tmp101_pkg;

    localparam int TEMP_W = 12;
    localparam int INT_W  = 8;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MSB,
        WAIT_LSB,
        WAIT_STOP
    } state_e;

endpackage

// File: rtl/tmp101_alert_comparator.sv
// Hysteresis alert register: sets at or above ALERT_HIGH, clears at or below
// ALERT_LOW, evaluated only when a new reading is published.
module tmp101_alert_comparator
    import tmp101_pkg::*;
#(
    parameter logic signed [INT_W-1:0] ALERT_HIGH = 8'sd30,
    parameter logic signed [INT_W-1:0] ALERT_LOW  = 8'sd25
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    publish_i,
    input  logic signed [INT_W-1:0] temp_int_i,
    output logic                    alert_o
);

    logic alert_q, alert_d;

    always_comb begin
        alert_d = alert_q;
        if (publish_i) begin
            if (temp_int_i >= ALERT_HIGH) begin
                alert_d = 1'b1;
            end else if (temp_int_i <= ALERT_LOW) begin
                alert_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alert_q <= 1'b0;
        end else begin
            alert_q <= alert_d;
        end
    end

    assign alert_o = alert_q;

endmodule

// File: rtl/tmp101_reading_assembler.sv
// Assembles two-byte TMP101 reads into a 12-bit reading with valid/overrun.
// Define TMP101_ALERT_COMPARE_EN to enable the hysteresis Alert output.
module tmp101_reading_assembler
    import tmp101_pkg::*;
#(
    parameter logic signed [INT_W-1:0] ALERT_HIGH = 8'sd30,
    parameter logic signed [INT_W-1:0] ALERT_LOW  = 8'sd25
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              FrameStart,
    input  logic              FrameStop,
    input  logic              ByteValid,
    input  logic [BYTE_W-1:0] ReceivedData,
    input  logic              TempAck,
    input  logic              ClearFlags,
    output logic [TEMP_W-1:0] Temperature,
    output logic [INT_W-1:0]  TempInteger,
    output logic              TempValid,
    output logic              Overrun,
    output logic              FrameError,
    output logic              Alert
);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] msb_q, msb_d;
    logic [TEMP_W-1:0] temp_q, temp_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              err_q, err_d;
    logic              publish;

    // FrameStart always resynchronises; it outranks any byte or stop.
    always_comb begin
        state_d = state_q;
        msb_d   = msb_q;
        err_d   = 1'b0;
        publish = 1'b0;
        if (FrameStart) begin
            state_d = WAIT_MSB;
            err_d   = (state_q == WAIT_LSB);
        end else begin
            case (state_q)
                WAIT_MSB: begin
                    if (FrameStop) begin
                        state_d = IDLE;
                        msb_d   = '0;
                        err_d   = 1'b1;
                    end else if (ByteValid) begin
                        msb_d   = ReceivedData;
                        state_d = WAIT_LSB;
                    end
                end
                WAIT_LSB: begin
                    if (ByteValid) begin
                        publish = 1'b1;
                        state_d = FrameStop ? IDLE : WAIT_STOP;
                    end else if (FrameStop) begin
                        state_d = IDLE;
                        msb_d   = '0;
                        err_d   = 1'b1;
                    end
                end
                WAIT_STOP: begin
                    err_d = ByteValid;
                    if (FrameStop) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    err_d = ByteValid;
                end
            endcase
        end
    end

    always_comb begin
        temp_d  = publish ? {msb_q, ReceivedData[7:4]} : temp_q;
        valid_d = publish | (valid_q & ~TempAck);
        ovr_d   = (publish & valid_q & ~TempAck) | (ovr_q & ~ClearFlags);
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            msb_q   <= '0;
            temp_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            msb_q   <= msb_d;
            temp_q  <= temp_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            err_q   <= err_d;
        end
    end

    assign Temperature = temp_q;
    assign TempInteger = temp_q[TEMP_W-1:TEMP_W-INT_W];
    assign TempValid   = valid_q;
    assign Overrun     = ovr_q;
    assign FrameError  = err_q;

    // Empty on purpose: only present when the thresholds are misordered.
    if (ALERT_LOW > ALERT_HIGH) begin : g_thresholds_misordered
    end

`ifdef TMP101_ALERT_COMPARE_EN
    tmp101_alert_comparator #(
        .ALERT_HIGH(ALERT_HIGH),
        .ALERT_LOW (ALERT_LOW)
    ) u_alert (
        .clk_i     (clock),
        .rst_ni    (Reset),
        .publish_i (publish),
        .temp_int_i($signed(msb_q)),
        .alert_o   (Alert)
    );
`else
    assign Alert = 1'b0;
`endif

endmodule

// File: tb/tb_tmp101_reading_assembler.sv
// Randomised and directed bench for tmp101_reading_assembler.
// A frame-level reference model is compared on every falling edge.
module tb_tmp101_reading_assembler;

    logic        clock = 1'b0;
    logic        Reset = 1'b0;
    logic        FrameStart = 1'b0;
    logic        FrameStop = 1'b0;
    logic        ByteValid = 1'b0;
    logic [7:0]  ReceivedData = 8'h00;
    logic        TempAck = 1'b0;
    logic        ClearFlags = 1'b0;
    logic [11:0] Temperature;
    logic [7:0]  TempInteger;
    logic        TempValid;
    logic        Overrun;
    logic        FrameError;
    logic        Alert;

    int nchecks = 0;
    int nerrors = 0;

    tmp101_reading_assembler dut (
        .clock       (clock),
        .Reset       (Reset),
        .FrameStart  (FrameStart),
        .FrameStop   (FrameStop),
        .ByteValid   (ByteValid),
        .ReceivedData(ReceivedData),
        .TempAck     (TempAck),
        .ClearFlags  (ClearFlags),
        .Temperature (Temperature),
        .TempInteger (TempInteger),
        .TempValid   (TempValid),
        .Overrun     (Overrun),
        .FrameError  (FrameError),
        .Alert       (Alert)
    );

    always #5 clock = ~clock;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: frame progress counted as "bytes still expected".
    // m_need: -1 = not in a frame, 2 = need MSB, 1 = need LSB, 0 = need STOP.
    int          m_need;
    logic [7:0]  m_msb;
    logic [11:0] m_temp;
    logic        m_valid, m_ovr, m_err, m_alert;

    always @(posedge clock or negedge Reset) begin : model
        int          need;
        logic        err, pub;
        logic signed [7:0] ti;
        if (!Reset) begin
            m_need  <= -1;
            m_msb   <= 8'h00;
            m_temp  <= 12'h000;
            m_valid <= 1'b0;
            m_ovr   <= 1'b0;
            m_err   <= 1'b0;
            m_alert <= 1'b0;
        end else begin
            need = m_need;
            err  = 1'b0;
            pub  = 1'b0;
            if (FrameStart) begin
                err  = (need == 1);
                need = 2;
            end else if (need > 0) begin
                if (ByteValid) begin
                    if (need == 2) m_msb <= ReceivedData;
                    pub  = (need == 1);
                    need = need - 1;
                    if (FrameStop) need = -1;
                end else if (FrameStop) begin
                    err  = 1'b1;
                    need = -1;
                end
            end else begin
                err = ByteValid;
                if (FrameStop) need = -1;
            end
            m_need <= need;
            m_err  <= err;
            if (pub) begin
                m_temp  <= {m_msb, ReceivedData[7:4]};
                m_valid <= 1'b1;
                if (m_valid && !TempAck) m_ovr <= 1'b1;
                else if (ClearFlags) m_ovr <= 1'b0;
`ifdef TMP101_ALERT_COMPARE_EN
                ti = m_msb;
                if (ti >= 8'sd30) m_alert <= 1'b1;
                else if (ti <= 8'sd25) m_alert <= 1'b0;
`endif
            end else begin
                if (TempAck) m_valid <= 1'b0;
                if (ClearFlags) m_ovr <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        chk("Temperature", 32'(Temperature), 32'(m_temp));
        chk("TempInteger", 32'(TempInteger), 32'(m_temp[11:4]));
        chk("TempValid", 32'(TempValid), 32'(m_valid));
        chk("Overrun", 32'(Overrun), 32'(m_ovr));
        chk("FrameError", 32'(FrameError), 32'(m_err));
        chk("Alert", 32'(Alert), 32'(m_alert));
    end

    task automatic step(bit fs, bit fp, bit bv, logic [7:0] d,
                        bit ack = 1'b0, bit clr = 1'b0);
        @(posedge clock);
        #1;
        FrameStart   = fs;
        FrameStop    = fp;
        ByteValid    = bv;
        ReceivedData = d;
        TempAck      = ack;
        ClearFlags   = clr;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame(logic [7:0] m, logic [7:0] l);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, m);
        step(1'b0, 1'b0, 1'b1, l);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        idle();
    endtask

    task automatic ack();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle();
    endtask

    logic [7:0] alert_rd [4];
    logic       alert_ex [4];

    initial begin
        #2;
        chk("rst Temperature", 32'(Temperature), 32'h0);
        chk("rst TempValid", 32'(TempValid), 32'h0);
        chk("rst Overrun", 32'(Overrun), 32'h0);
        chk("rst Alert", 32'(Alert), 32'h0);
        #10;
        Reset = 1'b1;

        frame(8'h19, 8'h00);
        chk("d038 Temperature", 32'(Temperature), 32'h190);
        chk("d038 TempInteger", 32'(TempInteger), 32'd25);
        chk("d038 TempValid", 32'(TempValid), 32'h1);
        chk("d038 FrameError", 32'(FrameError), 32'h0);
        ack();
        chk("ack TempValid", 32'(TempValid), 32'h0);

        frame(8'hE7, 8'h0F);
        chk("d039 Temperature", 32'(Temperature), 32'hE70);
        chk("d039 TempInteger", 32'(TempInteger), 32'hE7);
        chk("d039 Alert", 32'(Alert), 32'h0);
        ack();

        frame(8'h10, 8'h00);
        frame(8'h20, 8'h00);
        chk("d040 Temperature", 32'(Temperature), 32'h200);
        chk("d040 Overrun", 32'(Overrun), 32'h1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        idle();
        chk("d040 cleared", 32'(Overrun), 32'h0);
        ack();

        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h19);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        idle();
        chk("d041 FrameError", 32'(FrameError), 32'h1);
        chk("d041 TempValid", 32'(TempValid), 32'h0);
        step(1'b0, 1'b0, 1'b1, 8'h33);
        idle();
        chk("d041 idle byte err", 32'(FrameError), 32'h1);
        chk("d041 Temperature held", 32'(Temperature), 32'h200);

        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h12);
        step(1'b0, 1'b1, 1'b1, 8'h3C);
        idle();
        chk("stop+lsb Temperature", 32'(Temperature), 32'h123);
        chk("stop+lsb FrameError", 32'(FrameError), 32'h0);

        step(1'b1, 1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b0, 1'b1, 8'h05);
        step(1'b0, 1'b0, 1'b1, 8'h60, 1'b1);
        idle();
        chk("start+byte Temperature", 32'(Temperature), 32'h056);
        chk("pub+ack TempValid", 32'(TempValid), 32'h1);
        chk("pub+ack Overrun", 32'(Overrun), 32'h0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        idle();

        alert_rd = '{8'd31, 8'd27, 8'd25, 8'd26};
`ifdef TMP101_ALERT_COMPARE_EN
        alert_ex = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
        alert_ex = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 4; i++) begin
            frame(alert_rd[i], 8'h00);
            chk("d042 Alert", 32'(Alert), 32'(alert_ex[i]));
            ack();
        end

        frame(8'h2A, 8'h50);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h11);
        #1;
        Reset = 1'b0;
        #1;
        chk("d043 Temperature", 32'(Temperature), 32'h0);
        chk("d043 TempInteger", 32'(TempInteger), 32'h0);
        chk("d043 TempValid", 32'(TempValid), 32'h0);
        chk("d043 FrameError", 32'(FrameError), 32'h0);
        chk("d043 Alert", 32'(Alert), 32'h0);
        #3;
        Reset = 1'b1;
        step(1'b0, 1'b0, 1'b1, 8'h00);
        idle();
        chk("d043 lsb err", 32'(FrameError), 32'h1);
        chk("d043 no publish", 32'(TempValid), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            int  r;
            bit  fs, fp, bv;
            r  = $urandom_range(0, 99);
            fs = (r < 8);
            fp = !fs && (r >= 8) && (r < 18);
            bv = !fp && ($urandom_range(0, 99) < 40);
            step(fs, fp, bv, 8'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end
        idle();
        idle();
        #1;
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
